// File: rtl/merge_odd_even_stream.sv
// merge_odd_even_stream: re-interleaves an even-bit and an odd-bit lane into one word.
// Optional sticky skew event counter output enabled by `MERGE_ODD_EVEN_SKEW_CNT_EN.

module merge_odd_even_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;
  logic [AW:0]  one;

  assign one     = {{AW{1'b0}}, 1'b1};
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rdata_o = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (clr_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (wr_i) wp_d = wp_q + one;
      if (rd_i) rp_d = rp_q + one;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i && !clr_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end
endmodule

module merge_odd_even_stream #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [WIDTH/2-1:0] even_din,
  input  logic               even_valid,
  output logic               even_ready,
  input  logic [WIDTH/2-1:0] odd_din,
  input  logic               odd_valid,
  output logic               odd_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  input  logic               flush,
  output logic               skew_err
`ifdef MERGE_ODD_EVEN_SKEW_CNT_EN
  ,
  output logic [7:0]         skew_cnt
`endif
);
  localparam int HW = WIDTH / 2;

  typedef enum logic {RUN, ERR} state_t;

  state_t          state_q, state_d;
  logic            rdy1_q, rdy2_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            dv_q, dv_d;

  logic [HW-1:0]   e_head, o_head;
  logic [HW-1:0]   e_word, o_word;
  logic [WIDTH-1:0] merged;
  logic            e_full, e_empty;
  logic            o_full, o_empty;
  logic            skew, run_ok;
  logic            e_wr, o_wr;
  logic            e_push, o_push;
  logic            e_rd, o_rd;
  logic            pop;

  // Readys stay low until two edges after reset release.
  assign even_ready = rdy2_q && ((state_q == ERR) || !e_full);
  assign odd_ready  = rdy2_q && ((state_q == ERR) || !o_full);

  assign skew = (state_q == RUN) &&
                ((e_full && o_empty && even_valid) ||
                 (o_full && e_empty && odd_valid));

  assign run_ok = (state_q == RUN) && !flush && !skew;
  assign e_wr   = run_ok && even_valid && even_ready;
  assign o_wr   = run_ok && odd_valid && odd_ready;

  // An empty lane may be satisfied directly by this cycle's write.
  assign pop = run_ok &&
               (!e_empty || e_wr) &&
               (!o_empty || o_wr) &&
               (!dv_q || dout_ready);

  assign e_word = e_empty ? even_din : e_head;
  assign o_word = o_empty ? odd_din : o_head;
  assign e_push = e_wr && !(pop && e_empty);
  assign o_push = o_wr && !(pop && o_empty);
  assign e_rd   = pop && !e_empty;
  assign o_rd   = pop && !o_empty;

  always_comb begin
    merged = '0;
    for (int k = 0; k < HW; k++) begin
      merged[2*k]   = e_word[k];
      merged[2*k+1] = o_word[k];
    end
  end

  merge_odd_even_fifo #(
    .W     (HW),
    .DEPTH (DEPTH)
  ) u_even (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr_i   (flush),
    .wr_i    (e_push),
    .wdata_i (even_din),
    .rd_i    (e_rd),
    .rdata_o (e_head),
    .full_o  (e_full),
    .empty_o (e_empty)
  );

  merge_odd_even_fifo #(
    .W     (HW),
    .DEPTH (DEPTH)
  ) u_odd (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr_i   (flush),
    .wr_i    (o_push),
    .wdata_i (odd_din),
    .rd_i    (o_rd),
    .rdata_o (o_head),
    .full_o  (o_full),
    .empty_o (o_empty)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    if (flush) begin
      state_d = RUN;
      dout_d  = '0;
      dv_d    = 1'b0;
    end else if (skew) begin
      state_d = ERR;
      dv_d    = 1'b0;
    end else if (state_q == ERR) begin
      dv_d    = 1'b0;
    end else if (pop) begin
      dout_d  = merged;
      dv_d    = 1'b1;
    end else if (dout_ready) begin
      dv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      rdy1_q  <= 1'b1;
      rdy2_q  <= rdy1_q;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign skew_err   = (state_q == ERR);

`ifdef MERGE_ODD_EVEN_SKEW_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (skew && !flush && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign skew_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_merge_odd_even_stream.sv
// Randomised bench for merge_odd_even_stream with a queue-level reference model.
// Directed literal checks pin the model on the documented scenarios.

module tb_merge_odd_even_stream;
  localparam int W  = 20;
  localparam int HW = 10;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [HW-1:0] even_din = '0;
  logic [HW-1:0] odd_din = '0;
  logic          even_valid = 1'b0;
  logic          odd_valid = 1'b0;
  logic          dout_ready = 1'b0;
  logic          flush = 1'b0;
  logic          even_ready, odd_ready;
  logic          dout_valid, skew_err;
  logic [W-1:0]  dout;
`ifdef MERGE_ODD_EVEN_SKEW_CNT_EN
  logic [7:0]    skew_cnt;
`endif

  int errors = 0;
  int checks = 0;

  merge_odd_even_stream #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .even_din   (even_din),
    .even_valid (even_valid),
    .even_ready (even_ready),
    .odd_din    (odd_din),
    .odd_valid  (odd_valid),
    .odd_ready  (odd_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .flush      (flush),
    .skew_err   (skew_err)
`ifdef MERGE_ODD_EVEN_SKEW_CNT_EN
    ,
    .skew_cnt   (skew_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Weave by place value: even bit k weighs 4^k, odd bit k weighs 2*4^k.
  function automatic logic [31:0] weave(input logic [HW-1:0] e,
                                        input logic [HW-1:0] o);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int k = 0; k < HW; k++) begin
      r = r + ((int'(e) >> k) & 1) * p + ((int'(o) >> k) & 1) * 2 * p;
      p = p * 4;
    end
    return 32'(r);
  endfunction

  logic [HW-1:0] meq[$];
  logic [HW-1:0] moq[$];
  bit            m_ov;
  bit            m_err;
  logic [31:0]   m_od;
  int            m_edges;
  int            m_cnt;

  task automatic model_reset();
    meq.delete();
    moq.delete();
    m_ov    = 0;
    m_err   = 0;
    m_od    = 0;
    m_edges = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit er, input bit orr);
    if (flush) begin
      meq.delete();
      moq.delete();
      m_ov  = 0;
      m_od  = 0;
      m_err = 0;
    end else if (!m_err) begin
      if ((meq.size() == D && moq.size() == 0 && even_valid) ||
          (moq.size() == D && meq.size() == 0 && odd_valid)) begin
        m_err = 1;
        m_ov  = 0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        if (even_valid && er) meq.push_back(even_din);
        if (odd_valid && orr) moq.push_back(odd_din);
        if ((!m_ov || dout_ready) && meq.size() > 0 && moq.size() > 0) begin
          m_od = weave(meq.pop_front(), moq.pop_front());
          m_ov = 1;
        end else if (dout_ready) begin
          m_ov = 0;
        end
      end
    end
    if (m_edges < 2) m_edges++;
  endtask

  always @(negedge clk) begin : compare
    bit er;
    bit orr;
    if (!arst_n) model_reset();
    er  = (m_edges >= 2) && (m_err || meq.size() < D);
    orr = (m_edges >= 2) && (m_err || moq.size() < D);
    chk("even_ready", 32'(even_ready), 32'(er));
    chk("odd_ready", 32'(odd_ready), 32'(orr));
    chk("dout_valid", 32'(dout_valid), 32'(m_ov));
    if (m_ov) chk("dout", 32'(dout), m_od);
    chk("skew_err", 32'(skew_err), 32'(m_err));
`ifdef MERGE_ODD_EVEN_SKEW_CNT_EN
    chk("skew_cnt", 32'(skew_cnt), 32'(m_cnt));
`endif
    if (arst_n) model_step(er, orr);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit ev, input logic [HW-1:0] e,
                       input bit ov, input logic [HW-1:0] o);
    even_valid = ev;
    even_din   = e;
    odd_valid  = ov;
    odd_din    = o;
  endtask

  initial begin
    int pe, po, pr;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_eready", 32'(even_ready), 32'h0);
    chk("rst_skew", 32'(skew_err), 32'h0);
    cyc(2);
    arst_n = 1'b1;
    cyc(1);
    chk("rdy_edge1", 32'(even_ready), 32'h0);
    cyc(1);
    chk("rdy_edge2_e", 32'(even_ready), 32'h1);
    chk("rdy_edge2_o", 32'(odd_ready), 32'h1);

    dout_ready = 1'b1;
    drive(1, 10'h3FF, 1, 10'h000);
    cyc(1);
    chk("w55555", 32'(dout), 32'h55555);
    chk("w55555_v", 32'(dout_valid), 32'h1);
    drive(1, 10'h000, 1, 10'h3FF);
    cyc(1);
    chk("wAAAAA", 32'(dout), 32'hAAAAA);
    drive(1, 10'h001, 1, 10'h001);
    cyc(1);
    chk("w00003", 32'(dout), 32'h00003);
    drive(0, 0, 0, 0);
    cyc(1);

    for (int i = 1; i <= 3; i++) begin
      drive(1, HW'(i), 0, 0);
      cyc(1);
    end
    chk("lag_novalid", 32'(dout_valid), 32'h0);
    drive(0, 0, 1, 10'h001);
    cyc(1);
    chk("lag_w1", 32'(dout), 32'h3);
    drive(0, 0, 1, 10'h002);
    cyc(1);
    chk("lag_w2", 32'(dout), 32'hC);
    drive(0, 0, 1, 10'h003);
    cyc(1);
    chk("lag_w3", 32'(dout), 32'hF);
    chk("lag_noskew", 32'(skew_err), 32'h0);
    drive(0, 0, 0, 0);
    cyc(1);

    for (int i = 0; i < 4; i++) begin
      drive(1, HW'(i + 8), 0, 0);
      cyc(1);
    end
    chk("full_eready", 32'(even_ready), 32'h0);
    chk("full_noskew", 32'(skew_err), 32'h0);
    drive(1, 10'h00C, 0, 0);
    cyc(1);
    chk("err_skew", 32'(skew_err), 32'h1);
    chk("err_valid", 32'(dout_valid), 32'h0);
    chk("err_eready", 32'(even_ready), 32'h1);
    chk("err_oready", 32'(odd_ready), 32'h1);
`ifdef MERGE_ODD_EVEN_SKEW_CNT_EN
    chk("err_cnt", 32'(skew_cnt), 32'h1);
`endif
    drive(0, 0, 0, 0);
    cyc(2);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("flush_skew", 32'(skew_err), 32'h0);
    chk("flush_valid", 32'(dout_valid), 32'h0);
    drive(1, 10'h155, 1, 10'h2AA);
    cyc(1);
    chk("flush_w99999", 32'(dout), 32'h99999);
    drive(0, 0, 0, 0);
    cyc(1);

    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, HW'(i + 16), 1, HW'(i + 32));
      cyc(1);
      if (i == 0) chk("bp_first", 32'(dout), 32'h00900);
    end
    chk("bp_hold", 32'(dout), 32'h00900);
    chk("bp_eready", 32'(even_ready), 32'h0);
    chk("bp_oready", 32'(odd_ready), 32'h0);
    drive(0, 0, 0, 0);
    dout_ready = 1'b1;
    cyc(1);
    chk("bp_second", 32'(dout), 32'h00903);
    cyc(6);

    pe = 70;
    po = 70;
    pr = 70;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        pe = $urandom_range(20, 100);
        po = $urandom_range(20, 100);
        pr = $urandom_range(10, 100);
      end
      if (n == 1500) begin
        arst_n = 1'b0;
        cyc(1);
        arst_n = 1'b1;
      end
      drive($urandom_range(0, 99) < pe, HW'($urandom),
            $urandom_range(0, 99) < po, HW'($urandom));
      dout_ready = ($urandom_range(0, 99) < pr);
      flush = ($urandom_range(0, 99) < 2);
      cyc(1);
    end
    drive(0, 0, 0, 0);
    flush = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/merge_odd_even_stream.md
MERGE_ODD_EVEN_STREAM -- requirements
Module: merge_odd_even_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 20: merged word width; even, at least 2.
REQ-002 SHALL have parameter DEPTH, default 4: entries per lane FIFO; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port even_din, input, WIDTH/2 bits: even-bit lane data.
REQ-006 SHALL have port even_valid, input, 1 bit: even lane data is valid.
REQ-007 SHALL have port even_ready, output, 1 bit: the even lane FIFO can accept data.
REQ-008 SHALL have port odd_din, input, WIDTH/2 bits: odd-bit lane data.
REQ-009 SHALL have port odd_valid, input, 1 bit: odd lane data is valid.
REQ-010 SHALL have port odd_ready, output, 1 bit: the odd lane FIFO can accept data.
REQ-011 SHALL have port dout, output, WIDTH bits: merged word.
REQ-012 SHALL have port dout_valid, output, 1 bit: dout holds a valid word.
REQ-013 SHALL have port dout_ready, input, 1 bit: the downstream sink accepts dout.
REQ-014 SHALL have port flush, input, 1 bit: synchronous clear of all data and of the error state.
REQ-015 SHALL have port skew_err, output, 1 bit: sticky lane-skew error.

Function
REQ-016 SHALL produce each merged word as dout[2k] = even entry bit k and dout[2k+1] = odd entry bit k, for k = 0..WIDTH/2-1; this is the exact inverse of the odd/even lane split.
REQ-017 SHALL write a lane FIFO when that lane's valid and ready are both 1 in the same cycle; the two lanes are independent and may be skewed.
REQ-018 SHALL drive each lane's ready as "FIFO not full" while in state RUN.
REQ-019 SHALL pop both FIFOs together in one cycle when both are non-empty and the output register is empty or is being consumed (dout_valid and dout_ready both 1).
REQ-020 SHALL register dout and dout_valid; a pop loads the output register on the next edge.
REQ-021 SHALL have a minimum latency of 1 cycle: with the other lane already holding data and the output free, a lane write in cycle N gives dout_valid in cycle N+1.
REQ-022 SHALL hold dout stable while dout_valid is 1 and dout_ready is 0.
REQ-023 SHALL sustain one word per cycle: with both lanes valid and dout_ready held at 1, dout_valid stays 1 continuously.
REQ-024 SHALL allow a write and a pop on the same full FIFO in the same cycle only when the pop is guaranteed; ready reflects the current occupancy only, with no combinational path from dout_ready to either lane ready.
REQ-025 SHALL wrap the FIFO pointers modulo DEPTH; full and empty SHALL be distinguished by one extra pointer bit.
REQ-026 SHALL have two states, RUN and ERR.
REQ-027 SHALL move from RUN to ERR when one lane FIFO is full, the other lane FIFO is empty, and the full lane's valid is 1.
REQ-028 SHALL in ERR: set skew_err to 1, drive both lane readys to 1 and discard the input data, drive dout_valid to 0, and freeze both FIFOs.
REQ-029 SHALL on flush = 1, from either state: empty both FIFOs, clear the output register, clear skew_err, and enter RUN on the next edge.
REQ-030 SHALL give flush priority over a simultaneous lane write or pop; that data is discarded.

Reset
REQ-031 SHALL on arst_n = 0 immediately set: state RUN, both FIFOs empty, dout = 0, dout_valid = 0, skew_err = 0, and even_ready = odd_ready = 0.
REQ-032 SHALL, after arst_n is released, first assert even_ready and odd_ready on the second rising clk edge.
REQ-033 SHALL on reset mid-operation lose all buffered data, with no partial word emitted.

Configuration
REQ-034 SHALL, with macro MERGE_ODD_EVEN_SKEW_CNT_EN defined, add an output skew_cnt, 8 bits; it increments on each RUN-to-ERR transition, saturates at 255, is cleared by reset only, and is not affected by flush.
REQ-035 SHALL, without MERGE_ODD_EVEN_SKEW_CNT_EN, omit the skew_cnt port and its logic entirely; all other behaviour is unchanged.

Verification
REQ-036 SHALL cover: WIDTH = 20, even_din = 0x3FF and odd_din = 0x000 both valid, dout_ready = 1 -> dout = 0x55555 one cycle later.
REQ-037 SHALL cover: even_din = 0x000 and odd_din = 0x3FF -> dout = 0xAAAAA; then even_din = 0x001 and odd_din = 0x001 -> dout = 0x00003.
REQ-038 SHALL cover: the odd lane lags by 3 words (DEPTH = 4) -> no skew_err, and 3 words are emitted in order once the odd data arrives.
REQ-039 SHALL cover: the even lane sends 5 words while the odd lane is idle -> even_ready = 0 after 4 words; the 5th valid triggers ERR and skew_err = 1 (skew_cnt = 1 when the macro is defined).
REQ-040 SHALL cover: from ERR, pulse flush for 1 cycle -> skew_err = 0, dout_valid = 0, and the next matched pair is emitted normally.
REQ-041 SHALL cover: dout_ready held at 0 with a continuous input stream -> dout stable, each lane ready drops after DEPTH writes, and no word is lost or duplicated after dout_ready returns to 1.
